uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin transmit scheduler for MiniUART. It shares one serial TX line among NREQ byte requesters and frames each granted byte as 8N1: start, 8 data bits LSB first, stop. Bit timing comes only from the en_tx tick of the divisor counter. The block sits between the bus-side requesters and the txd pin.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- DATA_W, 8: data bits per frame.

Ports:
- clk  in  1  UART clock (same clock as the divisor).
- rst  in  1  reset, asynchronous, active-high.
- en_tx  in  1  one-cycle bit-period tick from the divisor.
- req  in  NREQ  per-requester transmit request, level.
- data  in  NREQ*DATA_W  byte for requester i at data[i*DATA_W +: DATA_W].
- ack  out  NREQ  one-cycle pulse when requester i's byte is latched.
- grant_id  out  $clog2(NREQ)  index of the last granted requester.
- txd  out  1  serial output; idle high.
- busy  out  1  high when a frame is in progress or the hold register is full.

## Operation
- Reset values: txd=1, ack=0, busy=0, grant_id=0, hold_valid=0, state IDLE. The round-robin pointer starts so that req[0] has top priority.
- Hold register is one byte deep.
  - Arbitration happens at any edge where hold_valid=0 and any unmasked req is high.
  - The grant goes to the first requester at or after pointer (last grant + 1 mod NREQ).
  - On that edge: hold is loaded with data[g], hold_valid is set, ack[g] is set for exactly one cycle, grant_id is set to g, and pointer is set to g+1 mod NREQ.
  - A requester whose ack is high is masked from arbitration that cycle.
  - A requester must drop req, or present its next byte, by the cycle after ack.
- Frame engine states: IDLE, START, DATA, STOP. The engine advances only on en_tx.
  - IDLE with en_tx and hold_valid: txd is set to 0, the shifter is loaded from hold, hold_valid is cleared, and the engine goes to START.
  - START with en_tx: txd is set to shift[0], bitcnt to 0, and the engine goes to DATA.
  - DATA with en_tx: if bitcnt=DATA_W-1, txd is set to 1 and the engine goes to STOP. Otherwise txd is set to shift[bitcnt+1] and bitcnt increments.
  - STOP with en_tx: if hold_valid, behave as IDLE's start transition, so back-to-back frames have exactly one stop bit. Otherwise go to IDLE.
- busy = (state != IDLE) | hold_valid. It is registered-equivalent, with no combinational path from req.
- Simultaneous events:
  - en_tx arrives on the same edge that loads an empty hold: the engine does not see the new byte until the next en_tx.
  - hold is consumed on an edge: arbitration cannot also happen on that edge, because hold_valid was 1. Arbitration resumes on the following edge.
- Reset mid-frame:
  - txd returns to 1 immediately.
  - The frame in flight and the held byte are discarded.
  - No ack is issued.

## Timing
- req to ack: 1 cycle, when hold is empty.
- Latch to falling edge of txd: up to one bit period (next en_tx) while idle.
- Frame length: 10 en_tx periods. txd changes only on the edge where en_tx=1.
- Sustained throughput with continuous requests: one byte per 10 bit periods, and no idle bits between frames.
- Fairness: with all requesters active, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grants.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum (IDLE/START/DATA/STOP),
  - UART_DATA_W=8,
  - UART_FRAME_BITS=10.
- Sub-module rr_arbiter(req, mask, pointer -> onehot grant, index) is purely combinational. The pointer register stays in uart_tx_sched.
- The engine shifter, bitcnt and hold register live in the top module.

## Test plan
- Reset, then no requests: txd=1 and busy=0 indefinitely. Assert rst mid-DATA: txd=1 in the same cycle, busy=0, and no ack.
- req[2]=1 with data 0xA5, en_tx every 16 cycles: ack[2] one cycle later, then the txd sequence 0,1,0,1,0,0,1,0,1,1 over 10 ticks. Then IDLE.
- req=4'b1111 held with new bytes after each ack: grant_id sequence 0,1,2,3,0. Frames are back-to-back with exactly one stop bit each.
- en_tx pulses on the same edge the hold loads from IDLE: the start bit appears at the next en_tx, not the current one.
- req[1] kept high through its ack cycle, then dropped: exactly one ack[1] and one frame.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared MiniUART transmit definitions: frame engine states and frame geometry.
package uart_ctrl_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index,
  output logic            any
);

  logic [NREQ-1:0] eligible;
  logic [IW:0]     slot;

  assign eligible = req & ~mask;

  // Walk NREQ slots starting at pointer, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    slot  = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, pointer} + (IW+1)'(k);
      if (slot >= (IW+1)'(NREQ)) slot = slot - (IW+1)'(NREQ);
      if (!any && eligible[slot[IW-1:0]]) begin
        any                  = 1'b1;
        grant[slot[IW-1:0]]  = 1'b1;
        index                = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin TX scheduler: arbitrates NREQ byte sources into a one-byte hold
// register and frames each byte as 8N1 on txd, paced by en_tx.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_tx,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     txd,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(DATA_W);

  logic [IW-1:0]     ptr;
  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              arb_fire;
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bitcnt;

  tx_state_e state, state_nxt;
  logic      txd_nxt;
  logic      consume;
  logic      bit_clr;
  logic      bit_inc;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .mask    (ack),
    .pointer (ptr),
    .grant   (arb_grant),
    .index   (arb_idx),
    .any     (arb_any)
  );

  // Only an empty hold may accept a byte; a consume edge never overlaps a load.
  assign arb_fire = arb_any & ~hold_valid;
  assign sel_data = data[arb_idx*DATA_W +: DATA_W];
  assign busy     = (state != IDLE) | hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ack        <= '0;
      grant_id   <= '0;
      ptr        <= '0;
    end else begin
      ack <= arb_fire ? arb_grant : '0;
      if (consume) begin
        hold_valid <= 1'b0;
      end else if (arb_fire) begin
        hold       <= sel_data;
        hold_valid <= 1'b1;
      end
      if (arb_fire) begin
        grant_id <= arb_idx;
        ptr      <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      txd    <= 1'b1;
      shift  <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nxt;
      txd   <= txd_nxt;
      if (consume) shift <= hold;
      if (bit_clr)      bitcnt <= '0;
      else if (bit_inc) bitcnt <= bitcnt + 1'b1;
    end
  end

  // STOP falls through to a new start bit when a byte is already waiting.
  always_comb begin
    state_nxt = state;
    txd_nxt   = txd;
    consume   = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    if (en_tx) begin
      unique case (state)
        IDLE: begin
          if (hold_valid) begin
            txd_nxt   = 1'b0;
            consume   = 1'b1;
            state_nxt = START;
          end
        end
        START: begin
          txd_nxt   = shift[0];
          bit_clr   = 1'b1;
          state_nxt = DATA;
        end
        DATA: begin
          if (bitcnt == BW'(DATA_W-1)) begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            txd_nxt = shift[bitcnt + 1'b1];
            bit_inc = 1'b1;
          end
        end
        STOP: begin
          if (hold_valid) begin
            txd_nxt   = 1'b0;
            consume   = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: grant and frame-bit scoreboards fed at
// stimulus/ack time, drained by a monitor sampling 1 time unit after clk.
module tb_uart_tx_sched;
  import uart_ctrl_pkg::*;

  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_tx;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0][7:0] cur_byte;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]  ack;
  logic [1:0]       grant_id;
  logic             txd;
  logic             busy;

  logic       tick_en;
  logic       man_tick;
  logic       auto_tick = 1'b0;
  logic [3:0] tcnt = '0;

  int checks = 0;
  int errors = 0;

  int exp_grants[$];
  logic exp_bits[$];
  int starts[$];
  int in_frame = 0;
  int nbit = 0;
  int tick_n = 0;
  int frame_cnt = 0;
  int ack_cnt[NREQ];

  uart_tx_sched #(.NREQ(NREQ), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_tx    (en_tx),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign data  = cur_byte;
  assign en_tx = tick_en ? auto_tick : man_tick;

  always @(negedge clk) begin
    tcnt      = tcnt + 4'd1;
    auto_tick = (tcnt == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: checks acks against expected grants, queues the framed byte,
  // then compares every bit of each frame seen on tick edges.
  always @(posedge clk) begin
    logic t;
    int   g;
    logic [7:0] b;
    logic eb;
    t = en_tx;
    #1;
    if (rst) begin
      in_frame = 0;
      nbit     = 0;
      exp_bits.delete();
    end else begin
      if (ack != '0) begin
        if (exp_grants.size() == 0) chk("sb_grant_avail", 32'(exp_grants.size()), 1);
        else begin
          g = exp_grants.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1 << g));
          chk("grant_id", 32'(grant_id), 32'(g));
          ack_cnt[g]++;
          b = cur_byte[g];
          exp_bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
          exp_bits.push_back(1'b1);
        end
      end
      if (t) begin
        tick_n++;
        if (in_frame != 0 || txd == 1'b0) begin
          if (in_frame == 0) begin
            in_frame = 1;
            nbit     = 0;
            starts.push_back(tick_n);
          end
          if (exp_bits.size() == 0) chk("sb_bits_avail", 32'(exp_bits.size()), 1);
          else begin
            eb = exp_bits.pop_front();
            chk("txd_bit", 32'(txd), 32'(eb));
          end
          nbit++;
          if (nbit == UART_FRAME_BITS) begin
            in_frame = 0;
            frame_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int base_f, base_a, base_s, id, n;
    rst      = 1'b1;
    req      = '0;
    tick_en  = 1'b1;
    man_tick = 1'b0;
    cur_byte = '0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;

    // Reset state and idle line
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (25) @(negedge clk);
      chk("idle_txd", 32'(txd), 1);
      chk("idle_busy", 32'(busy), 0);
    end

    // Reset in the middle of the data bits of an all-zero byte
    cur_byte[0] = 8'h00;
    exp_grants.push_back(0);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    for (n = 0; n < 400 && !(in_frame != 0 && nbit >= 4); n++) @(negedge clk);
    chk("middata_reached", 32'(in_frame != 0 && nbit >= 4), 1);
    base_a = ack_cnt[0];
    rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ack", 32'(ack), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_ack", 32'(ack_cnt[0] - base_a), 0);
    chk("midrst_idle_txd", 32'(txd), 1);

    // Single byte 0xA5 from requester 2
    base_f = frame_cnt;
    cur_byte[2] = 8'hA5;
    exp_grants.push_back(2);
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("req_to_ack", 32'(ack), 32'(4'b0100));
    @(negedge clk);
    req = '0;
    for (n = 0; n < 600 && (exp_bits.size() != 0 || busy); n++) @(negedge clk);
    chk("a5_drain_busy", 32'(busy), 0);
    chk("a5_frames", 32'(frame_cnt - base_f), 1);
    chk("a5_txd_idle", 32'(txd), 1);

    // All requesters active: rotation and back-to-back frames
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_byte = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 4; k++) exp_grants.push_back(k);
    exp_grants.push_back(0);
    base_s = starts.size();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (n = 0; n < 400 && ack == '0; n++) @(negedge clk);
      chk("rr_ack_seen", 32'(ack != '0), 1);
      id = 0;
      for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
      cur_byte[id] = ~cur_byte[id];
      if (k == 4) req = '0;
      @(negedge clk);
    end
    for (n = 0; n < 1200 && (exp_bits.size() != 0 || busy); n++) @(negedge clk);
    chk("rr_drain_busy", 32'(busy), 0);
    chk("rr_frame_starts", 32'(starts.size() - base_s), 5);
    if (starts.size() - base_s == 5)
      for (int k = 1; k < 5; k++)
        chk("b2b_gap", 32'(starts[base_s+k] - starts[base_s+k-1]), UART_FRAME_BITS);

    // Tick on the same edge that loads an empty hold
    tick_en = 1'b0;
    base_f = frame_cnt;
    cur_byte[0] = 8'h3C;
    exp_grants.push_back(0);
    @(negedge clk);
    req      = 4'b0001;
    man_tick = 1'b1;
    @(posedge clk);
    #1;
    chk("same_edge_txd", 32'(txd), 1);
    chk("same_edge_busy", 32'(busy), 1);
    @(negedge clk);
    man_tick = 1'b0;
    req      = '0;
    repeat (3) @(negedge clk);
    chk("same_edge_hold_txd", 32'(txd), 1);
    for (int p = 0; p < 11; p++) begin
      man_tick = 1'b1;
      @(posedge clk);
      #1;
      if (p == 0) chk("start_next_tick", 32'(txd), 0);
      @(negedge clk);
      man_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("manual_busy", 32'(busy), 0);
    chk("manual_frames", 32'(frame_cnt - base_f), 1);
    tick_en = 1'b1;

    // req[1] held through its ack cycle, then dropped
    base_f = frame_cnt;
    base_a = ack_cnt[1];
    cur_byte[1] = 8'h5A;
    exp_grants.push_back(1);
    req = 4'b0010;
    @(posedge clk);
    #1;
    chk("hold_req_ack", 32'(ack), 32'(4'b0010));
    @(negedge clk);
    @(negedge clk);
    req = '0;
    for (n = 0; n < 600 && (exp_bits.size() != 0 || busy); n++) @(negedge clk);
    chk("one_ack1", 32'(ack_cnt[1] - base_a), 1);
    chk("one_frame1", 32'(frame_cnt - base_f), 1);
    chk("grants_consumed", 32'(exp_grants.size()), 0);
    chk("bits_consumed", 32'(exp_bits.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
